// File: rtl/fetch_sequencer.sv
// fetch_sequencer -- instruction fetch sequencer.
//
// Owns the program counter, issues fetches to the IFU (1-cycle read latency),
// buffers returned (pc, instruction) pairs and presents them to decode over a
// valid/ready handshake. A redirect replaces the pc, flushes the buffer and
// squashes any fetch still in flight.
//
// Ports:
//   clock           system clock, all state on rising edge
//   reset           asynchronous, active-low reset
//   fetch_add       address presented to the IFU (always the current pc)
//   fetch_req       fetch issued this cycle
//   inst_code       IFU read data, valid the cycle after fetch_req
//   redirect_valid  branch/jump taken, pc replaced by redirect_pc
//   redirect_pc     redirect target
//   out_valid       buffer head valid to decode
//   out_ready       decode accepts head
//   out_inst        head instruction
//   out_pc          head instruction address
//   fault           misaligned redirect seen (sticky until reset)
//
// Build option:
//   FETCH_ALIGN_CHECK_EN  when defined, a redirect_pc with bits [1:0] != 0
//                         raises fault, leaves pc unchanged and parks the
//                         sequencer in FLUSH until reset. When undefined,
//                         fault is tied 0 and redirect_pc[1:0] are forced to 0.

module fetch_sequencer #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] PC_STEP   = 32'd4,
   parameter int unsigned BUF_DEPTH = 2
) (
   input  logic        clock,
   input  logic        reset,
   output logic [31:0] fetch_add,
   output logic        fetch_req,
   input  logic [31:0] inst_code,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_inst,
   output logic [31:0] out_pc,
   output logic        fault
);

   localparam int unsigned PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int unsigned CW = PW + 1;

   typedef enum logic [1:0] {
      ST_WAIT,
      ST_RUN,
      ST_FLUSH
   } state_t;

   state_t          state_q, state_d;
   logic [31:0]     pc_q, pc_d;
   logic            infl_q, infl_d;
   logic [31:0]     tag_q, tag_d;
   logic [31:0]     mem_inst_q [BUF_DEPTH];
   logic [31:0]     mem_inst_d [BUF_DEPTH];
   logic [31:0]     mem_pc_q   [BUF_DEPTH];
   logic [31:0]     mem_pc_d   [BUF_DEPTH];
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]   count_q, count_d;

   logic            push;
   logic            pop;
   logic [31:0]     used;
   logic            park;
   logic            load_pc;
   logic [31:0]     redirect_tgt;

`ifdef FETCH_ALIGN_CHECK_EN
   logic            fault_q;
   logic            misalign;

   assign misalign     = |redirect_pc[1:0];
   assign park         = fault_q;
   assign load_pc      = redirect_valid & ~misalign & ~fault_q;
   assign redirect_tgt = redirect_pc;
   assign fault        = fault_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) fault_q <= 1'b0;
      else        fault_q <= fault_q | (redirect_valid & misalign);
   end
`else
   logic            unused_low_bits;

   assign unused_low_bits = ^redirect_pc[1:0];
   assign park            = 1'b0;
   assign load_pc         = redirect_valid;
   assign redirect_tgt    = {redirect_pc[31:2], 2'b00};
   assign fault           = 1'b0;
`endif

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state_q <= ST_WAIT;
      else        state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      if (redirect_valid || park) begin
         state_d = ST_FLUSH;
      end else begin
         unique case (state_q)
            ST_WAIT:  state_d = ST_RUN;
            ST_FLUSH: state_d = ST_RUN;
            default:  state_d = ST_RUN;
         endcase
      end
   end

   // ---------------- FSM: outputs ----------------
   // The credit count nets out a same-cycle pop so a depth-2 buffer can
   // sustain one instruction per cycle; occupancy + in-flight never exceeds
   // BUF_DEPTH, so a return always finds a free slot.
   always_comb begin
      used      = 32'(count_q) + 32'(infl_q) - 32'(pop);
      fetch_req = (state_q == ST_RUN) && !redirect_valid && (used < BUF_DEPTH);
   end

   // ---------------- Datapath ----------------
   assign fetch_add = pc_q;
   assign out_valid = (count_q != '0);
   assign out_inst  = mem_inst_q[rd_ptr_q];
   assign out_pc    = mem_pc_q[rd_ptr_q];

   // A redirect squashes the returning fetch and suppresses the pop.
   assign push = infl_q && !redirect_valid;
   assign pop  = out_valid && out_ready && !redirect_valid;

   always_comb begin
      pc_d       = pc_q;
      infl_d     = fetch_req;
      tag_d      = tag_q;
      mem_inst_d = mem_inst_q;
      mem_pc_d   = mem_pc_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;

      if (load_pc) begin
         pc_d = redirect_tgt;
      end else if (fetch_req) begin
         pc_d = pc_q + PC_STEP;
      end

      if (fetch_req) begin
         tag_d = pc_q;
      end

      if (redirect_valid) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            mem_inst_d[wr_ptr_q] = inst_code;
            mem_pc_d[wr_ptr_q]   = tag_q;
            wr_ptr_d             = wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pc_q     <= RESET_PC;
         infl_q   <= 1'b0;
         tag_q    <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
            mem_inst_q[i] <= '0;
            mem_pc_q[i]   <= '0;
         end
      end else begin
         pc_q       <= pc_d;
         infl_q     <= infl_d;
         tag_q      <= tag_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         mem_inst_q <= mem_inst_d;
         mem_pc_q   <= mem_pc_d;
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer: directed scenarios plus randomized
// ready/redirect traffic, checked against a queue-based reference model.

module tb_fetch_sequencer;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          DEPTH    = 2;

   logic        clock;
   logic        reset;
   logic [31:0] fetch_add;
   logic        fetch_req;
   logic [31:0] inst_code;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_inst;
   logic [31:0] out_pc;
   logic        fault;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   logic [31:0] q_pc[$];
   logic [31:0] q_inst[$];
   logic [31:0] m_pc;
   bit          m_infl;
   logic [31:0] m_infl_pc;
   int          m_hold;
   bit          m_fault;

   fetch_sequencer #(
      .RESET_PC (RESET_PC),
      .PC_STEP  (32'd4),
      .BUF_DEPTH(DEPTH)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .fetch_add     (fetch_add),
      .fetch_req     (fetch_req),
      .inst_code     (inst_code),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_inst      (out_inst),
      .out_pc        (out_pc),
      .fault         (fault)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [31:0] ifu_mem(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   // IFU: one-cycle read latency; garbage when no fetch was issued.
   always @(posedge clock) begin
      if (fetch_req) inst_code <= ifu_mem(fetch_add);
      else           inst_code <= $urandom();
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      q_pc.delete();
      q_inst.delete();
      m_pc      = RESET_PC;
      m_infl    = 0;
      m_infl_pc = '0;
      m_hold    = 1;
      m_fault   = 0;
   endtask

   // One clock cycle: called just after a falling edge.
   task automatic cycle(input logic rdy, input logic rv, input logic [31:0] rpc);
      bit exp_valid, pop, exp_req, misal;
      int used;
      out_ready      = rdy;
      redirect_valid = rv;
      redirect_pc    = rpc;
      exp_valid = (q_pc.size() != 0);
      pop       = exp_valid && rdy && !rv;
      used      = q_pc.size() - int'(pop) + int'(m_infl);
      exp_req   = (m_hold == 0) && !rv && (used < DEPTH);
      #1;
      check("out_valid", 32'(out_valid), 32'(exp_valid));
      if (exp_valid) begin
         check("out_pc", out_pc, q_pc[0]);
         check("out_inst", out_inst, q_inst[0]);
      end
      check("fetch_req", 32'(fetch_req), 32'(exp_req));
      check("fetch_add", fetch_add, m_pc);
      check("fault", 32'(fault), 32'(m_fault));
      @(posedge clock);
      if (rv) begin
         q_pc.delete();
         q_inst.delete();
         m_infl = 0;
         m_hold = 1;
         misal  = (rpc[1:0] != 2'b00);
`ifdef FETCH_ALIGN_CHECK_EN
         if (misal || m_fault) m_fault = 1;
         else                  m_pc    = rpc;
`else
         if (misal) m_pc = rpc & 32'hFFFF_FFFC;
         else       m_pc = rpc;
`endif
      end else begin
         if (pop) begin
            void'(q_pc.pop_front());
            void'(q_inst.pop_front());
         end
         if (m_infl) begin
            q_pc.push_back(m_infl_pc);
            q_inst.push_back(ifu_mem(m_infl_pc));
         end
         m_infl = exp_req;
         if (exp_req) begin
            m_infl_pc = m_pc;
            m_pc      = m_pc + 32'd4;
         end
         if (m_hold > 0 && !m_fault) m_hold--;
      end
      @(negedge clock);
   endtask

   initial begin
      logic        rdy_r;
      logic        rv_r;
      logic [31:0] rpc_r;

      reset          = 1'b0;
      out_ready      = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      model_reset();

      // Reset values
      @(negedge clock);
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_inst", out_inst, 32'd0);
      check("rst_out_pc", out_pc, 32'd0);
      check("rst_fetch_req", 32'(fetch_req), 32'd0);
      check("rst_fetch_add", fetch_add, RESET_PC);
      check("rst_fault", 32'(fault), 32'd0);
      @(negedge clock);
      reset = 1'b1;

      // Stall 6 cycles, then drain and stream
      for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, '0);
      check("stall_occupancy", 32'(q_pc.size()), 32'd2);
      for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, '0);

      // Fill, then redirect to 0x40 with ready high in the redirect cycle
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, '0);
      cycle(1'b1, 1'b1, 32'h0000_0040);
      for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, '0);

      // Wrap-around of pc
      cycle(1'b1, 1'b1, 32'hFFFF_FFF8);
      for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, '0);

      // Back-to-back redirects: last one wins
      cycle(1'b1, 1'b1, 32'h0000_0100);
      cycle(1'b1, 1'b1, 32'h0000_0200);
      for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, '0);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         rdy_r = ($urandom_range(0, 3) != 0);
         rv_r  = ($urandom_range(0, 11) == 0);
         rpc_r = $urandom() & 32'hFFFF_FFFC;
         cycle(rdy_r, rv_r, rpc_r);
      end

      // Asynchronous reset mid-stream with a full buffer
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, '0);
      check("full_before_reset", 32'(out_valid), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      check("async_out_valid", 32'(out_valid), 32'd0);
      check("async_fetch_add", fetch_add, RESET_PC);
      check("async_fetch_req", 32'(fetch_req), 32'd0);
      model_reset();
      @(negedge clock);
      reset = 1'b1;

      // Redirect in WAIT still passes through FLUSH
      cycle(1'b1, 1'b1, 32'h0000_0080);
      for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, '0);

      // Misaligned redirect target
      cycle(1'b1, 1'b1, 32'h0000_0042);
      for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, '0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
